// File: rtl/instr_seq_ctl_pkg.sv
// Shared opcodes, state encoding and strobe bundle for the instruction sequencer.
// Optional single-step mode is enabled by defining INSTR_SEQ_STEP_EN.
package cpu_pkg;

  localparam logic [2:0] HLT  = 3'd0;
  localparam logic [2:0] SKZ  = 3'd1;
  localparam logic [2:0] ADD  = 3'd2;
  localparam logic [2:0] ANDD = 3'd3;
  localparam logic [2:0] XORR = 3'd4;
  localparam logic [2:0] LDA  = 3'd5;
  localparam logic [2:0] STO  = 3'd6;
  localparam logic [2:0] JMP  = 3'd7;

  typedef enum logic [3:0] {
    IDLE,
    S0, S1, S2, S3,
    S4, S5, S6, S7,
    HALTED,
    WAIT
  } state_t;

  typedef struct packed {
    logic inc_pc;
    logic load_pc;
    logic load_ir;
    logic load_acc;
    logic rd;
    logic wr;
    logic datactl_ena;
    logic halt;
  } row_t;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == ADD) || (op == ANDD) ||
           (op == XORR) || (op == LDA);
  endfunction

endpackage

// File: rtl/instr_seq_ctl_if.sv
// Sequencer <-> datapath strobe bundle.
// step/stalled exist only when INSTR_SEQ_STEP_EN is defined.
interface instr_seq_if #(
  parameter int OP_W = 3
);
  logic            ena;
  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            inc_pc;
  logic            load_pc;
  logic            load_ir;
  logic            load_acc;
  logic            rd;
  logic            wr;
  logic            datactl_ena;
  logic            halt;
`ifdef INSTR_SEQ_STEP_EN
  logic            step;
  logic            stalled;

  modport master (
    input  ena, opcode, zero, step,
    output inc_pc, load_pc, load_ir, load_acc,
    output rd, wr, datactl_ena, halt, stalled
  );

  modport slave (
    output ena, opcode, zero, step,
    input  inc_pc, load_pc, load_ir, load_acc,
    input  rd, wr, datactl_ena, halt, stalled
  );
`else
  modport master (
    input  ena, opcode, zero,
    output inc_pc, load_pc, load_ir, load_acc,
    output rd, wr, datactl_ena, halt
  );

  modport slave (
    output ena, opcode, zero,
    input  inc_pc, load_pc, load_ir, load_acc,
    input  rd, wr, datactl_ena, halt
  );
`endif
endinterface

// File: rtl/instr_seq_ctl.sv
// 8-state instruction-cycle sequencer with registered Moore strobes.
// Define INSTR_SEQ_STEP_EN to park in WAIT after S7 until a step rising edge.
module instr_seq_ctl
  import cpu_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  instr_seq_if.master io
);

  state_t          state, nxt;
  logic [OP_W-1:0] op_q, op_d;
  row_t            row_q, row_d;
  logic            alu, jmp, sto, skz;

  assign alu = is_alu_op(op_q);
  assign jmp = (op_q == JMP);
  assign sto = (op_q == STO);
  assign skz = (op_q == SKZ);

`ifdef INSTR_SEQ_STEP_EN
  logic step_q, step_rise;

  assign step_rise  = io.step & ~step_q;
  assign io.stalled = (state == WAIT);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      op_q  <= '0;
      row_q <= '0;
`ifdef INSTR_SEQ_STEP_EN
      step_q <= 1'b0;
`endif
    end else begin
      state <= nxt;
      op_q  <= op_d;
      row_q <= row_d;
`ifdef INSTR_SEQ_STEP_EN
      step_q <= io.step;
`endif
    end
  end

  always_comb begin
    nxt   = state;
    op_d  = op_q;
    row_d = '0;

    if (state == HALTED) begin
      nxt = HALTED;
    end else if (!io.ena) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: nxt = S0;
        S0:   nxt = S1;
        S1:   nxt = S2;
        S2: begin
          nxt  = S3;
          op_d = io.opcode;
        end
        S3:   nxt = (op_q == HLT) ? HALTED : S4;
        S4:   nxt = S5;
        S5:   nxt = S6;
        S6:   nxt = S7;
`ifdef INSTR_SEQ_STEP_EN
        S7:   nxt = WAIT;
        WAIT: nxt = step_rise ? S0 : WAIT;
`else
        S7:   nxt = S0;
`endif
        default: nxt = IDLE;
      endcase
    end

    // rows are loaded on the edge that enters the state
    unique case (nxt)
      S0: begin
        row_d.rd      = 1'b1;
        row_d.load_ir = 1'b1;
      end
      S1: begin
        row_d.rd      = 1'b1;
        row_d.load_ir = 1'b1;
        row_d.inc_pc  = 1'b1;
      end
      S3: row_d.inc_pc = 1'b1;
      S4: begin
        row_d.rd          = alu;
        row_d.load_pc     = jmp;
        row_d.datactl_ena = sto;
      end
      S5: begin
        row_d.rd          = alu;
        row_d.load_acc    = alu;
        row_d.load_pc     = jmp;
        row_d.inc_pc      = jmp | (skz & io.zero);
        row_d.wr          = sto;
        row_d.datactl_ena = sto;
      end
      S6: begin
        row_d.rd          = alu;
        row_d.datactl_ena = sto;
      end
      S7:     row_d.inc_pc = skz & io.zero;
      HALTED: row_d.halt   = 1'b1;
      default: row_d = '0;
    endcase
  end

  assign io.inc_pc      = row_q.inc_pc;
  assign io.load_pc     = row_q.load_pc;
  assign io.load_ir     = row_q.load_ir;
  assign io.load_acc    = row_q.load_acc;
  assign io.rd          = row_q.rd;
  assign io.wr          = row_q.wr;
  assign io.datactl_ena = row_q.datactl_ena;
  assign io.halt        = row_q.halt;

endmodule

// File: tb/tb_instr_seq_ctl.sv
// Self-checking bench for instr_seq_ctl: directed instructions plus
// randomized opcode/zero/ena traffic against a cycle-position model.
module tb_instr_seq_ctl;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  logic clk = 1'b0;
  logic rst;

  instr_seq_if #(.OP_W(3)) bus ();

  instr_seq_ctl #(.OP_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // model: pos -1 = idle, 0..7 = instruction cycle, 8 = waiting for step
  int         pos      = -1;
  bit         halted   = 1'b0;
  logic [2:0] op_m     = 3'd0;
  bit         z_m      = 1'b0;
  bit         step_prev = 1'b0;
  bit         auto_step = 1'b1;

  task automatic model_edge();
    bit st;
    st = 1'b0;
`ifdef INSTR_SEQ_STEP_EN
    st = bus.step;
`endif
    if (!rst) begin
      pos = -1; halted = 1'b0; op_m = 3'd0;
      step_prev = 1'b0; z_m = 1'b0;
      return;
    end
    if (!halted) begin
      if (!bus.ena) pos = -1;
      else if (pos == -1) pos = 0;
      else if (pos == 3 && op_m == OP_HLT) begin
        halted = 1'b1; pos = -1;
      end else if (pos == 2) begin
        op_m = bus.opcode; pos = 3;
      end else if (pos == 7) begin
`ifdef INSTR_SEQ_STEP_EN
        pos = 8;
`else
        pos = 0;
`endif
      end else if (pos == 8) begin
        if (st && !step_prev) pos = 0;
      end else pos = pos + 1;
    end
    z_m = bus.zero;
    step_prev = st;
  endtask

  function automatic logic [7:0] exp_vec();
    bit alu, inc, lpc, lir, lacc, rd, wr, dc;
    if (halted) return 8'b0000_0001;
    alu  = (op_m == OP_ADD) || (op_m == OP_AND) ||
           (op_m == OP_XOR) || (op_m == OP_LDA);
    lir  = (pos == 0) || (pos == 1);
    rd   = lir || (alu && pos >= 4 && pos <= 6);
    lacc = alu && pos == 5;
    lpc  = (op_m == OP_JMP) && (pos == 4 || pos == 5);
    wr   = (op_m == OP_STO) && pos == 5;
    dc   = (op_m == OP_STO) && pos >= 4 && pos <= 6;
    inc  = (pos == 1) || (pos == 3) ||
           (pos == 5 && op_m == OP_JMP) ||
           ((pos == 5 || pos == 7) && op_m == OP_SKZ && z_m);
    return {inc, lpc, lir, lacc, rd, wr, dc, 1'b0};
  endfunction

  task automatic check(input string tag);
    logic [7:0] got, want;
    got  = {bus.inc_pc, bus.load_pc, bus.load_ir, bus.load_acc,
            bus.rd, bus.wr, bus.datactl_ena, bus.halt};
    want = exp_vec();
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s pos=%0d got=%b exp=%b", tag, pos, got, want);
    end
    n_assert++;
    assert (!(bus.wr && !bus.datactl_ena)) else begin
      n_fail++;
      $error("FAIL %s wr_dctl got=%b exp=1", tag, bus.datactl_ena);
    end
    n_assert++;
    assert (!(bus.rd && bus.wr)) else begin
      n_fail++;
      $error("FAIL %s rd_wr got=11 exp=not-both", tag);
    end
`ifdef INSTR_SEQ_STEP_EN
    n_assert++;
    assert (bus.stalled === (pos == 8)) else begin
      n_fail++;
      $error("FAIL %s stalled got=%b exp=%b", tag, bus.stalled, pos == 8);
    end
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
`ifdef INSTR_SEQ_STEP_EN
    if (auto_step) bus.step = (pos == 8) ? ~bus.step : 1'b0;
`endif
  endtask

  task automatic bound_ok(input string tag, input int guard);
    n_assert++;
    assert (guard < 40) else begin
      n_fail++;
      $error("FAIL %s timeout got=%0d exp=<40", tag, guard);
    end
  endtask

  task automatic run_to(input string tag, input int target);
    int guard;
    guard = 0;
    while (pos != target && guard < 40) begin
      tick(tag);
      guard++;
    end
    bound_ok(tag, guard);
  endtask

  // op held through the S2->S3 edge, then the live opcode is scrambled
  task automatic run_instr(input string tag, input logic [2:0] op,
                           input logic z);
    bus.opcode = op;
    bus.zero   = z;
    if (pos == 3) tick(tag);
    run_to(tag, 3);
    bus.opcode = (op == OP_JMP) ? OP_ADD : 3'($urandom_range(1, 7));
    run_to(tag, 7);
  endtask

  initial begin
    rst = 1'b0;
    bus.ena = 1'b1;
    bus.opcode = OP_LDA;
    bus.zero = 1'b0;
`ifdef INSTR_SEQ_STEP_EN
    bus.step = 1'b0;
`endif
    tick("reset0");
    tick("reset1");
    rst = 1'b1;

    run_instr("lda", OP_LDA, 1'b0);
    run_instr("sto", OP_STO, 1'b1);
    run_instr("skz_z1", OP_SKZ, 1'b1);
    run_instr("skz_z0", OP_SKZ, 1'b0);
    run_instr("jmp", OP_JMP, 1'b0);
    run_instr("add", OP_ADD, 1'b1);

    bus.opcode = OP_STO;
    run_to("pre_drop", 5);
    bus.ena = 1'b0;
    tick("ena_drop");
    tick("ena_low");
    bus.ena = 1'b1;
    tick("ena_back");
    run_instr("after_drop", OP_XOR, 1'b0);

`ifdef INSTR_SEQ_STEP_EN
    auto_step = 1'b0;
    bus.step = 1'b0;
    tick("wait_enter");
    tick("wait_hold");
    bus.step = 1'b1;
    for (int i = 0; i < 20; i++) tick("step_level");
    bus.step = 1'b0;
    auto_step = 1'b1;
    tick("step_release");
`endif

    for (int i = 0; i < 300; i++) begin
      bus.opcode = 3'($urandom_range(1, 7));
      bus.zero   = 1'($urandom);
      bus.ena    = ($urandom_range(0, 19) != 0);
      tick("random");
    end

    bus.ena = 1'b1;
    bus.opcode = OP_HLT;
    run_to("hlt", 3);
    tick("hlt_enter");
    for (int i = 0; i < 20; i++) begin
      bus.ena = 1'($urandom);
      bus.opcode = 3'($urandom_range(0, 7));
      tick("halted");
    end
    rst = 1'b0;
    tick("hlt_reset");
    rst = 1'b1;
    bus.ena = 1'b1;
    bus.opcode = OP_LDA;
    tick("post_reset");
    run_instr("post_lda", OP_LDA, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_seq_ctl.md
Name: instr_seq_ctl

Overview:
- Instruction-cycle sequencer for the 8-bit RISC CPU.
- Steps an 8-state machine per instruction and drives the datapath strobes: PC increment/load, IR load, ACC load, memory read/write, data-bus enable and halt.
- Sits between the clock/phase generator and the datapath (PC, IR, ACC/ALU, data-bus driver, RAM/ROM). Its `ena` is the generator's phase-enable output.

Parameters:
- OP_W, 3, opcode width; fixed encoding below, only 3 is legal.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- ena  in  1  sequencer enable from clock/phase generator
- opcode  in  OP_W  IR opcode field; must be valid before the S2->S3 edge
- zero  in  1  ACC==0 flag from ALU
- inc_pc  out  1  PC+1 strobe
- load_pc  out  1  PC <= IR address field
- load_ir  out  1  IR byte capture
- load_acc  out  1  ACC <= ALU result
- rd  out  1  memory read enable
- wr  out  1  memory write strobe
- datactl_ena  out  1  ACC drives data bus
- halt  out  1  CPU halted

Behaviour:
- Reset:
  - rst=0 at an edge forces state=IDLE, all outputs 0 and op_q=0.
  - Reset has priority over everything, including mid-instruction and HALTED.
- Opcodes: HLT=0, SKZ=1, ADD=2, ANDD=3, XORR=4, LDA=5, STO=6, JMP=7. The ALU group is ADD, ANDD, XORR and LDA.
- States: IDLE, S0..S7, HALTED.
- Registered Moore outputs: the edge that enters Sn loads that state's row. Outputs equal row(Sn) for the whole cycle spent in Sn.
- ena=0 at any edge outside HALTED: next state IDLE, outputs all 0. An in-flight instruction is abandoned and restarts at S0.
- IDLE with ena=1 -> S0.
- Transitions:
  - Sn -> Sn+1 for n=0..6.
  - S7 -> S0.
  - S3 -> HALTED when op_q=HLT.
- op_q latches opcode on the S2->S3 edge. Rows S3..S7 use op_q, never the live opcode.
- Rows (signals not listed are 0):
  - S0: rd, load_ir (high IR byte).
  - S1: rd, load_ir, inc_pc (low IR byte).
  - S2: all 0.
  - S3: inc_pc.
  - S4:
    - ALU group: rd.
    - JMP: load_pc.
    - STO: datactl_ena.
  - S5:
    - ALU group: rd, load_acc.
    - JMP: load_pc, inc_pc.
    - STO: wr, datactl_ena.
    - SKZ with zero=1: inc_pc.
  - S6:
    - ALU group: rd.
    - STO: datactl_ena.
  - S7: SKZ with zero=1 (zero sampled again on the S6->S7 edge): inc_pc.
- HALTED (entered from S3 on HLT):
  - halt=1, all other outputs 0.
  - Ignores ena and opcode. Exits only via reset.
- Invariants:
  - wr=1 implies datactl_ena=1.
  - rd and wr are never both 1.
  - Instruction latency is 8 cycles S0..S7. Back-to-back instructions run with no gap.

Optional Feature:
- Macro: INSTR_SEQ_STEP_EN.
- When defined:
  - Adds input `step` (1 bit) and output `stalled` (1 bit).
  - S7 goes to a WAIT state (all strobes 0, stalled=1) instead of S0.
  - WAIT -> S0 on the first edge with step=1. Only the rising edge of step counts: a level held high advances exactly one instruction.
  - Reset clears WAIT and the step edge detector.
- When undefined: neither port exists and S7 -> S0 directly.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams HLT..JMP;
  - state encoding for IDLE, S0-S7, HALTED, WAIT;
  - an is_alu_op() function.
- Sub-module: none; the row decode stays inside one module.

Test Plan:
- Reset, then ena=1 with opcode=LDA and zero=0 -> rd=1 in S0, S1, S4, S5, S6; load_acc=1 only in S5; inc_pc=1 in S1 and S3; next S0 on cycle 9.
- STO -> datactl_ena=1 in S4..S6; wr=1 only in S5; rd=0 in S4..S7.
- SKZ with zero=1 -> inc_pc=1 in S1, S3, S5, S7. SKZ with zero=0 -> inc_pc=1 only in S1, S3.
- JMP -> load_pc=1 in S4 and S5, inc_pc=1 in S5. Changing opcode to ADD after S3 does not alter the rows.
- HLT -> halt=1 from the cycle after S3, held for 20 cycles with ena toggling; rst=0 for one edge clears it to 0.
- ena=0 asserted during S5 -> next cycle IDLE with all outputs 0; ena=1 -> S0 row next. With INSTR_SEQ_STEP_EN: stalled=1 after S7, one step pulse -> exactly one further instruction.
